// File: rtl/demux_pkg.sv
// Shared types and helpers for the serial-to-parallel demux/deserializer.
// The PARITY state code is only reachable when DEMUX_PARITY_EN is defined.
package demux_pkg;

  // FSM state encoding, kept as plain constants for legacy tool flows
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_COLLECT = 2'd1;
  localparam state_t ST_PARITY  = 2'd2;

  // Parallel word width derived from the select index width
  function automatic int unsigned word_width(input int unsigned sel_width);
    return 32'd1 << sel_width;
  endfunction

endpackage

// File: rtl/demux_bit_counter.sv
// Wrapping bit-position counter for the deserializer.
// Advances on en_i, wraps W-1 -> 0, synchronous active-low clear.
module demux_bit_counter
  import demux_pkg::*;
#(
  parameter int SEL_WIDTH = 2
) (
  input  logic                 CLK,
  input  logic                 clr_n_i,
  input  logic                 en_i,
  output logic [SEL_WIDTH-1:0] count_o,
  output logic                 last_o
);

  localparam int unsigned W = word_width(SEL_WIDTH);
  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(W - 1);

  logic [SEL_WIDTH-1:0] count_q;
  logic [SEL_WIDTH-1:0] count_d;

  // Next count: natural overflow of the SEL_WIDTH-bit register gives the wrap
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = count_q + SEL_WIDTH'(1);
    end
  end

  // Count register with synchronous clear
  always_ff @(posedge CLK) begin
    if (!clr_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == LAST_IDX);

endmodule

// File: rtl/demux_deser.sv
// Serial-to-parallel demultiplexer: each accepted bit is steered into one
// position of a 2**SEL_WIDTH-bit word; the finished word is presented with a
// one-cycle valid pulse. Optional trailing even-parity bit when the macro
// DEMUX_PARITY_EN is defined; otherwise demux_PAR_ERR is tied low.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_IDLE    | no partial word held, waiting for the first bit
//   ST_COLLECT | partial word held, collecting data bits
//   ST_PARITY  | all data bits held, waiting for the parity bit (macro)
module demux_deser
  import demux_pkg::*;
#(
  parameter int SEL_WIDTH = 2,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        demux_IN,
  input  logic                        demux_IN_VALID,
  output logic [(2**SEL_WIDTH)-1:0]   demux_OUT,
  output logic                        demux_OUT_VALID,
  output logic [SEL_WIDTH-1:0]        demux_SEL,
  output logic                        demux_BUSY,
  output logic                        demux_PAR_ERR
);

  localparam int unsigned W = word_width(SEL_WIDTH);
  localparam logic [SEL_WIDTH-1:0] MAX_IDX = SEL_WIDTH'(W - 1);

  state_t               state_q;
  state_t               state_d;
  logic [W-1:0]         shadow_q;
  logic [W-1:0]         shadow_d;
  logic [W-1:0]         out_q;
  logic [W-1:0]         out_d;
  logic                 out_valid_q;
  logic                 out_valid_d;

  logic [SEL_WIDTH-1:0] count;
  logic                 last;
  logic                 accept;
  logic                 in_parity;
  logic                 cnt_en;
  logic                 word_done;
  logic [SEL_WIDTH-1:0] sel;

  assign accept = demux_IN_VALID;

`ifdef DEMUX_PARITY_EN
  assign in_parity = (state_q == ST_PARITY);
`else
  assign in_parity = 1'b0;
`endif

  // The parity bit does not occupy a word position, so it must not advance
  // the counter; it has already wrapped to 0 after the last data bit.
  assign cnt_en = accept & ~in_parity;

  demux_bit_counter #(
    .SEL_WIDTH (SEL_WIDTH)
  ) u_bit_counter (
    .CLK     (CLK),
    .clr_n_i (RST),
    .en_i    (cnt_en),
    .count_o (count),
    .last_o  (last)
  );

  // Target bit position; pinned to the final data position during parity
  always_comb begin
    sel = LSB_FIRST ? count : (MAX_IDX - count);
    if (in_parity) begin
      sel = LSB_FIRST ? MAX_IDX : '0;
    end
  end

  // Shadow word update: only the addressed bit changes on an accepted data bit
  always_comb begin
    shadow_d = shadow_q;
    if (accept && !in_parity) begin
      shadow_d[sel] = demux_IN;
    end
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (accept && last) begin
`ifdef DEMUX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef DEMUX_PARITY_EN
      ST_PARITY: begin
        if (accept) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Word completion; the last data bit bypasses the shadow register so the
  // output is ready one cycle after it without an extra pipeline stage.
  always_comb begin
`ifdef DEMUX_PARITY_EN
    word_done = accept & in_parity;
`else
    word_done = accept & last & (state_q == ST_COLLECT);
`endif
    out_d       = out_q;
    out_valid_d = word_done;
    if (word_done) begin
`ifdef DEMUX_PARITY_EN
      out_d = shadow_q;
`else
      out_d = shadow_d;
`endif
    end
  end

  // State, shadow and output registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef DEMUX_PARITY_EN
  logic par_err_q;
  logic par_err_d;

  // Even parity over data plus parity bit; flagged alongside OUT_VALID
  always_comb begin
    par_err_d = word_done & ((^shadow_q) ^ demux_IN);
  end

  // Parity error pulse register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign demux_PAR_ERR = par_err_q;
`else
  assign demux_PAR_ERR = 1'b0;
`endif

  assign demux_OUT       = out_q;
  assign demux_OUT_VALID = out_valid_q;
  assign demux_SEL       = sel;
  assign demux_BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_demux_deser.sv
// Self-checking bench for demux_deser: directed scenarios plus a random
// stream, both checked against a queue-based word model. Two instances run
// side by side on the same stream, one LSB-first and one MSB-first.
module tb_demux_deser;

  localparam int SW = 2;
  localparam int W  = 4;

`ifdef DEMUX_PARITY_EN
  localparam int NEED = W + 1;
`else
  localparam int NEED = W;
`endif

  logic         CLK;
  logic         RST;
  logic         din;
  logic         dvalid;

  logic [W-1:0]  out_l, out_m;
  logic          v_l, v_m;
  logic [SW-1:0] sel_l, sel_m;
  logic          busy_l, busy_m;
  logic          perr_l, perr_m;

  demux_deser #(.SEL_WIDTH(SW), .LSB_FIRST(1'b1)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .demux_IN        (din),
    .demux_IN_VALID  (dvalid),
    .demux_OUT       (out_l),
    .demux_OUT_VALID (v_l),
    .demux_SEL       (sel_l),
    .demux_BUSY      (busy_l),
    .demux_PAR_ERR   (perr_l)
  );

  demux_deser #(.SEL_WIDTH(SW), .LSB_FIRST(1'b0)) dut_msb (
    .CLK             (CLK),
    .RST             (RST),
    .demux_IN        (din),
    .demux_IN_VALID  (dvalid),
    .demux_OUT       (out_m),
    .demux_OUT_VALID (v_m),
    .demux_SEL       (sel_m),
    .demux_BUSY      (busy_m),
    .demux_PAR_ERR   (perr_m)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: the bits of the word in progress, in arrival order
  int           q_bits[$];
  logic [W-1:0] m_out_l, m_out_m;
  logic         m_valid, m_perr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_update(input logic r, input logic v, input logic b);
    int par;
    if (!r) begin
      q_bits.delete();
      m_out_l = '0;
      m_out_m = '0;
      m_valid = 1'b0;
      m_perr  = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_perr  = 1'b0;
      if (v) begin
        q_bits.push_back(int'(b));
        if (q_bits.size() == NEED) begin
          par = 0;
          for (int i = 0; i < W; i++) begin
            m_out_l[i]       = q_bits[i][0];
            m_out_m[W-1-i]   = q_bits[i][0];
          end
          for (int i = 0; i < NEED; i++) par ^= q_bits[i];
          m_valid = 1'b1;
          m_perr  = (NEED > W) && (par != 0);
          q_bits.delete();
        end
      end
    end
  endtask

  task automatic compare_all();
    int n;
    int e_sel_l, e_sel_m;
    n = q_bits.size();
    e_sel_l = (n < W) ? n : W - 1;
    e_sel_m = (n < W) ? W - 1 - n : 0;
    check("out_lsb",   32'(out_l),  32'(m_out_l));
    check("out_msb",   32'(out_m),  32'(m_out_m));
    check("valid_lsb", 32'(v_l),    32'(m_valid));
    check("valid_msb", 32'(v_m),    32'(m_valid));
    check("sel_lsb",   32'(sel_l),  32'(e_sel_l));
    check("sel_msb",   32'(sel_m),  32'(e_sel_m));
    check("busy_lsb",  32'(busy_l), 32'(n > 0));
    check("busy_msb",  32'(busy_m), 32'(n > 0));
    check("perr_lsb",  32'(perr_l), 32'(m_perr));
    check("perr_msb",  32'(perr_m), 32'(m_perr));
  endtask

  // One clock: drive inputs, let the edge happen, update model, sample at +1
  task automatic step(input logic r, input logic v, input logic b);
    RST    = r;
    dvalid = v;
    din    = b;
    @(posedge CLK);
    model_update(r, v, b);
    #1;
    compare_all();
  endtask

  task automatic send_bits(input logic [7:0] bits, input int cnt);
    for (int i = 0; i < cnt; i++) step(1'b1, 1'b1, bits[i]);
  endtask

  initial begin
    logic [7:0] pat;
    RST    = 1'b0;
    dvalid = 1'b0;
    din    = 1'b0;
    q_bits.delete();
    m_out_l = '0;
    m_out_m = '0;
    m_valid = 1'b0;
    m_perr  = 1'b0;
    #2;

    // Reset state
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("rst_out",   32'(out_l),  32'h0);
    check("rst_valid", 32'(v_l),    32'h0);
    check("rst_busy",  32'(busy_l), 32'h0);
    check("rst_sel",   32'(sel_l),  32'h0);
    check("rst_perr",  32'(perr_l), 32'h0);
    step(1'b1, 1'b0, 1'b0);

`ifndef DEMUX_PARITY_EN
    // 0,1,0,1 -> 1010 (LSB-first), 0101 (MSB-first)
    pat = 8'b0000_1010;
    send_bits(pat, 4);
    check("w1_out",   32'(out_l), 32'hA);
    check("w1_valid", 32'(v_l),   32'h1);
    check("w1_msb",   32'(out_m), 32'h5);
    step(1'b1, 1'b0, 1'b0);
    check("w1_pulse", 32'(v_l),    32'h0);
    check("w1_busy",  32'(busy_l), 32'h0);
    check("w1_hold",  32'(out_l),  32'hA);

    // Gapped: 1,1, three idle cycles, 0,1 -> 1011
    pat = 8'b0000_0011;
    send_bits(pat, 2);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'(i));
      check("gap_sel",   32'(sel_l), 32'h2);
      check("gap_valid", 32'(v_l),   32'h0);
    end
    pat = 8'b0000_0010;
    send_bits(pat, 2);
    check("gap_out", 32'(out_l), 32'hB);
    check("gap_v",   32'(v_l),   32'h1);
    step(1'b1, 1'b0, 1'b0);

    // Back-to-back: 1,0,0,0,1,1,1,1
    pat = 8'b1111_0001;
    send_bits(pat, 4);
    check("b2b_out1", 32'(out_l), 32'h1);
    check("b2b_v1",   32'(v_l),   32'h1);
    pat = 8'b0000_1111;
    send_bits(pat, 1);
    check("b2b_busy", 32'(busy_l), 32'h1);
    send_bits(pat, 3);
    check("b2b_out2", 32'(out_l), 32'hF);
    check("b2b_v2",   32'(v_l),   32'h1);
    step(1'b1, 1'b0, 1'b0);

    // Reset mid-word, then 1,1,1,0 -> 0111
    pat = 8'b0000_0011;
    send_bits(pat, 2);
    step(1'b0, 1'b0, 1'b0);
    check("rmw_valid", 32'(v_l),   32'h0);
    check("rmw_sel",   32'(sel_l), 32'h0);
    check("rmw_out",   32'(out_l), 32'h0);
    pat = 8'b0000_0111;
    send_bits(pat, 4);
    check("rmw_word",  32'(out_l), 32'h7);

    // MSB-first: 1,0,0,0 -> 1000
    pat = 8'b0000_0001;
    send_bits(pat, 4);
    check("msb_out", 32'(out_m), 32'h8);
    check("msb_v",   32'(v_m),   32'h1);
    step(1'b1, 1'b0, 1'b0);
`else
    // Data 1,0,1,1 + parity 1 -> 1101, no error
    pat = 8'b0001_1101;
    send_bits(pat, 4);
    check("par_wait_v",   32'(v_l),   32'h0);
    check("par_sel_lsb",  32'(sel_l), 32'h3);
    check("par_sel_msb",  32'(sel_m), 32'h0);
    check("par_busy",     32'(busy_l), 32'h1);
    step(1'b1, 1'b1, 1'b1);
    check("par_ok_out",  32'(out_l),  32'hD);
    check("par_ok_v",    32'(v_l),    32'h1);
    check("par_ok_err",  32'(perr_l), 32'h0);
    step(1'b1, 1'b0, 1'b0);
    // Same data + parity 0 -> error pulse alongside valid
    send_bits(pat, 4);
    step(1'b1, 1'b1, 1'b0);
    check("par_bad_out", 32'(out_l),  32'hD);
    check("par_bad_v",   32'(v_l),    32'h1);
    check("par_bad_err", 32'(perr_l), 32'h1);
    step(1'b1, 1'b0, 1'b0);
    check("par_err_pulse", 32'(perr_l), 32'h0);
`endif

    // Random stream with sparse resets and gaps
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom));
    end
    step(1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
